// File: rtl/dram_arb_pkg.sv
// Shared types and default widths for the DRAM user-port arbiter.
package dram_arb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH     = 27;
    localparam int unsigned DEF_DATA_WIDTH     = 128;
    localparam int unsigned DEF_MASK_WIDTH     = DEF_DATA_WIDTH / 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        CALIB = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        RWAIT = 2'd3
    } state_t;

    typedef struct packed {
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
        logic [DEF_MASK_WIDTH-1:0] wmask;
    } cmd_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant: on a tie the port that did not win last time wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant_c,
    output logic       grant_idx_c
);

    always_comb begin
        grant_idx_c = req[1];
        if (req == 2'b11) begin
            grant_idx_c = ~last_grant;
        end
        grant_c = 2'b00;
        if (req != 2'b00) begin
            grant_c[grant_idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM user port between fetch (port 0) and data (port 1), one transaction at a time.
// Optional read watchdog with sticky timeout_err: define DRAM_PORT_ARBITER_TIMEOUT_EN.
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned MASK_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [MASK_WIDTH-1:0] m0_wmask,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [MASK_WIDTH-1:0] m1_wmask,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  dram_ren,
    output logic                  dram_wen,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic [DATA_WIDTH-1:0] dram_wdata,
    output logic [MASK_WIDTH-1:0] dram_wmask,
    output logic                  dram_user_busy,
`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
    output logic                  timeout_err,
`endif
    input  logic                  dram_init_calib_complete,
    input  logic                  dram_busy,
    input  logic [DATA_WIDTH-1:0] dram_rdata,
    input  logic                  dram_rdata_valid
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    cmd_t                  cmd_q, cmd_d;
    logic                  m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
    logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
    logic [DATA_WIDTH-1:0] resp_data_c;
    logic                  resp_fire_c;
    logic [1:0]            grant_c;
    logic                  grant_idx_c;

`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    assign timeout_err = err_q;
`endif

    rr_arbiter2 u_rr (
        .req         ({m1_valid, m0_valid}),
        .last_grant  (last_grant_q),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    assign dram_addr      = ADDR_WIDTH'(cmd_q.addr);
    assign dram_wdata     = DATA_WIDTH'(cmd_q.wdata);
    assign dram_wmask     = MASK_WIDTH'(cmd_q.wmask);
    assign dram_user_busy = 1'b0;
    assign m0_rvalid      = m0_rvalid_q;
    assign m1_rvalid      = m1_rvalid_q;
    assign m0_rdata       = m0_rdata_q;
    assign m1_rdata       = m1_rdata_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= CALIB;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            cmd_q        <= '0;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            cmd_q        <= cmd_d;
            m0_rvalid_q  <= m0_rvalid_d;
            m1_rvalid_q  <= m1_rvalid_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        cmd_d        = cmd_q;
        m0_rvalid_d  = 1'b0;
        m1_rvalid_d  = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        m0_ready     = 1'b0;
        m1_ready     = 1'b0;
        dram_ren     = 1'b0;
        dram_wen     = 1'b0;
        resp_fire_c  = 1'b0;
        resp_data_c  = dram_rdata;
`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
        cnt_d        = '0;
        err_d        = err_q;
`endif
        unique case (state_q)
            CALIB: begin
                if (dram_init_calib_complete) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                // Losing calibration only takes effect between transactions
                if (!dram_init_calib_complete) begin
                    state_d = CALIB;
                end else if (grant_c != 2'b00) begin
                    m0_ready     = grant_c[0];
                    m1_ready     = grant_c[1];
                    last_grant_d = grant_idx_c;
                    owner_d      = grant_idx_c;
                    state_d      = ISSUE;
                    if (grant_idx_c) begin
                        cmd_d.we    = m1_we;
                        cmd_d.addr  = DEF_ADDR_WIDTH'(m1_addr);
                        cmd_d.wdata = DEF_DATA_WIDTH'(m1_wdata);
                        cmd_d.wmask = DEF_MASK_WIDTH'(m1_wmask);
                    end else begin
                        cmd_d.we    = m0_we;
                        cmd_d.addr  = DEF_ADDR_WIDTH'(m0_addr);
                        cmd_d.wdata = DEF_DATA_WIDTH'(m0_wdata);
                        cmd_d.wmask = DEF_MASK_WIDTH'(m0_wmask);
                    end
                end
            end
            ISSUE: begin
                if (!dram_busy) begin
                    dram_ren = ~cmd_q.we;
                    dram_wen = cmd_q.we;
                    state_d  = cmd_q.we ? IDLE : RWAIT;
                end
            end
            RWAIT: begin
                if (dram_rdata_valid) begin
                    resp_fire_c = 1'b1;
                end
`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_fire_c = 1'b1;
                    resp_data_c = '1;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
                if (resp_fire_c) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        m1_rvalid_d = 1'b1;
                        m1_rdata_d  = resp_data_c;
                    end else begin
                        m0_rvalid_d = 1'b1;
                        m0_rdata_d  = resp_data_c;
                    end
                end
            end
            default: state_d = CALIB;
        endcase
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed self-checking bench for dram_port_arbiter (timeout section needs DRAM_PORT_ARBITER_TIMEOUT_EN).
module tb_dram_port_arbiter;
    import dram_arb_pkg::*;

    localparam int unsigned AW = 27;
    localparam int unsigned DW = 128;
    localparam int unsigned MW = 16;

    logic          clock = 1'b0;
    logic          resetn;
    logic          m0_valid, m0_ready, m0_we, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [MW-1:0] m0_wmask;
    logic          m1_valid, m1_ready, m1_we, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [MW-1:0] m1_wmask;
    logic          dram_ren, dram_wen, dram_user_busy;
    logic [AW-1:0] dram_addr;
    logic [DW-1:0] dram_wdata;
    logic [MW-1:0] dram_wmask;
    logic          dram_init_calib_complete, dram_busy, dram_rdata_valid;
    logic [DW-1:0] dram_rdata;
`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
    logic          timeout_err;
`endif

    int checks = 0;
    int failures = 0;
    int ren_cnt = 0, wen_cnt = 0, rv0_cnt = 0, rv1_cnt = 0, rdy0_cnt = 0;
    int grant_n = 0;
    int grant_log [64];
    int b_ren, b_wen, b_rv0, b_rv1, b_rdy0, b_grant;

    localparam logic [DW-1:0] D0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [DW-1:0] D1 = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;
    localparam logic [DW-1:0] DX = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    localparam logic [DW-1:0] WB = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;

    dram_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MASK_WIDTH     (MW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock                    (clock),
        .resetn                   (resetn),
        .m0_valid                 (m0_valid),
        .m0_ready                 (m0_ready),
        .m0_we                    (m0_we),
        .m0_addr                  (m0_addr),
        .m0_wdata                 (m0_wdata),
        .m0_wmask                 (m0_wmask),
        .m0_rvalid                (m0_rvalid),
        .m0_rdata                 (m0_rdata),
        .m1_valid                 (m1_valid),
        .m1_ready                 (m1_ready),
        .m1_we                    (m1_we),
        .m1_addr                  (m1_addr),
        .m1_wdata                 (m1_wdata),
        .m1_wmask                 (m1_wmask),
        .m1_rvalid                (m1_rvalid),
        .m1_rdata                 (m1_rdata),
        .dram_ren                 (dram_ren),
        .dram_wen                 (dram_wen),
        .dram_addr                (dram_addr),
        .dram_wdata               (dram_wdata),
        .dram_wmask               (dram_wmask),
        .dram_user_busy           (dram_user_busy),
`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
        .timeout_err              (timeout_err),
`endif
        .dram_init_calib_complete (dram_init_calib_complete),
        .dram_busy                (dram_busy),
        .dram_rdata               (dram_rdata),
        .dram_rdata_valid         (dram_rdata_valid)
    );

    always #5 clock = ~clock;

    // Event counters sampled mid-cycle, away from the active edge
    always @(negedge clock) begin
        if (dram_ren)  ren_cnt++;
        if (dram_wen)  wen_cnt++;
        if (m0_rvalid) rv0_cnt++;
        if (m1_rvalid) rv1_cnt++;
        if (m0_ready) begin
            rdy0_cnt++;
            grant_log[grant_n % 64] = 0;
            grant_n++;
        end
        if (m1_ready) begin
            grant_log[grant_n % 64] = 1;
            grant_n++;
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic snap();
        b_ren = ren_cnt; b_wen = wen_cnt; b_rv0 = rv0_cnt; b_rv1 = rv1_cnt;
        b_rdy0 = rdy0_cnt; b_grant = grant_n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        m0_valid = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
        m1_valid = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
        dram_init_calib_complete = 1'b0; dram_busy = 1'b0;
        dram_rdata = '0; dram_rdata_valid = 1'b0;
        repeat (3) tick();

        check("rst_m0_ready", m0_ready, 0);
        check("rst_m1_ready", m1_ready, 0);
        check("rst_ren", dram_ren, 0);
        check("rst_wen", dram_wen, 0);
        check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
        check("rst_addr", dram_addr, 0);
        check("rst_user_busy", dram_user_busy, 0);
        check("rst_state", dut.state_q, CALIB);
        resetn = 1'b1;

        // Calibration gate with a read pending on port 0
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 27'h55;
        snap();
        repeat (50) tick();
        check("calib_no_ready", rdy0_cnt - b_rdy0, 0);
        check("calib_no_strobe", (ren_cnt - b_ren) + (wen_cnt - b_wen), 0);
        dram_init_calib_complete = 1'b1;
        #1;
        check("calib_ready_same_cycle", m0_ready, 0);
        tick();
        check("calib_ready_next", m0_ready, 1);
        tick();
        m0_valid = 1'b0;
        #1;
        check("calib_ren", dram_ren, 1);
        check("calib_addr", dram_addr, 27'h55);
        tick();
        check("calib_ren_one_cycle", dram_ren, 0);
        repeat (3) tick();
        dram_rdata = D0; dram_rdata_valid = 1'b1;
        tick();
        dram_rdata_valid = 1'b0; dram_rdata = DX;
        #1;
        check("rd0_rvalid", m0_rvalid, 1);
        check("rd0_rdata", m0_rdata, D0);
        check("rd0_m1_quiet", m1_rvalid, 0);
        tick();
        check("rd0_pulse_end", m0_rvalid, 0);
        check("rd0_rdata_hold", m0_rdata, D0);

        // Single read on port 1 with 20-cycle DRAM latency
        snap();
        m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 27'h0000100;
        #1;
        for (int i = 0; i < 10 && !m1_ready; i++) tick();
        check("rd1_grant", m1_ready, 1);
        tick();
        m1_valid = 1'b0;
        #1;
        check("rd1_ren", dram_ren, 1);
        check("rd1_addr", dram_addr, 27'h0000100);
        repeat (20) tick();
        dram_rdata = D1; dram_rdata_valid = 1'b1;
        tick();
        dram_rdata_valid = 1'b0; dram_rdata = DX;
        for (int i = 0; i < 5 && !m1_rvalid; i++) tick();
        check("rd1_rvalid", m1_rvalid, 1);
        check("rd1_rdata", m1_rdata, D1);
        repeat (3) tick();
        check("rd1_one_rvalid", rv1_cnt - b_rv1, 1);
        check("rd1_no_m0_rvalid", rv0_cnt - b_rv0, 0);
        check("rd1_one_ren", ren_cnt - b_ren, 1);

        // Contention: both ports write continuously for 16 cycles
        snap();
        m0_valid = 1'b1; m0_we = 1'b1; m0_addr = 27'h200; m0_wdata = WB; m0_wmask = 16'hFFFF;
        m1_valid = 1'b1; m1_we = 1'b1; m1_addr = 27'h300; m1_wdata = ~WB; m1_wmask = 16'hF0F0;
        repeat (16) tick();
        m0_valid = 1'b0; m1_valid = 1'b0;
        repeat (2) tick();
        check("cont_grants", grant_n - b_grant, 8);
        check("cont_wen_eq_grants", wen_cnt - b_wen, 8);
        check("cont_g0", grant_log[(b_grant + 0) % 64], 0);
        check("cont_g1", grant_log[(b_grant + 1) % 64], 1);
        check("cont_g2", grant_log[(b_grant + 2) % 64], 0);
        check("cont_g3", grant_log[(b_grant + 3) % 64], 1);

        // Back-pressure: busy for 7 cycles while the write sits in ISSUE
        m0_valid = 1'b1; m0_we = 1'b1; m0_addr = 27'h3; m0_wdata = WB; m0_wmask = 16'h00FF;
        #1;
        check("bp_grant", m0_ready, 1);
        tick();
        m0_valid = 1'b0; dram_busy = 1'b1;
        snap();
        #1;
        check("bp_no_wen_first", dram_wen, 0);
        repeat (7) tick();
        check("bp_no_strobe", (wen_cnt - b_wen) + (ren_cnt - b_ren), 0);
        dram_busy = 1'b0;
        #1;
        check("bp_wen", dram_wen, 1);
        check("bp_addr", dram_addr, 27'h3);
        check("bp_mask", dram_wmask, 16'h00FF);
        check("bp_wdata", dram_wdata, WB);
        repeat (2) tick();
        check("bp_single_wen", wen_cnt - b_wen, 1);

`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
        // Read that never returns data
        check("to_err_clear", timeout_err, 0);
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 27'h9;
        #1;
        check("to_grant", m0_ready, 1);
        tick();
        m0_valid = 1'b0;
        tick();
        repeat (15) tick();
        check("to_not_yet", m0_rvalid, 0);
        tick();
        check("to_rvalid", m0_rvalid, 1);
        check("to_rdata_ones", m0_rdata, {DW{1'b1}});
        check("to_err_set", timeout_err, 1);
        repeat (3) tick();
        check("to_err_sticky", timeout_err, 1);
`endif

        // Reset while a port-1 read waits for data
        m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 27'h7;
        #1;
        check("rr_grant", m1_ready, 1);
        tick();
        m1_valid = 1'b0;
        tick();
        check("rr_in_rwait", dut.state_q, RWAIT);
        snap();
        resetn = 1'b0;
        #1;
        check("rr_state", dut.state_q, CALIB);
        check("rr_addr_zero", dram_addr, 0);
        check("rr_strobes_zero", {dram_ren, dram_wen}, 0);
        check("rr_rdata_zero", m1_rdata | m0_rdata, 0);
`ifdef DRAM_PORT_ARBITER_TIMEOUT_EN
        check("rr_err_cleared", timeout_err, 0);
`endif
        tick();
        resetn = 1'b1;
        dram_rdata = D1; dram_rdata_valid = 1'b1;
        tick();
        dram_rdata_valid = 1'b0;
        repeat (5) tick();
        check("rr_no_rvalid", (rv1_cnt - b_rv1) + (rv0_cnt - b_rv0), 0);
        check("rr_stray_ignored", m1_rdata, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
